sd_cmd_framer: RTL and testbench

Command-framing stage between the SD sector-read controller and the byte-wide SPI controller. It accepts an SD command as a 6-bit index and a 32-bit argument, and builds the 48-bit SPI-mode frame with a CRC7. It issues the frame as six byte transfers, then polls with 0xFF bytes until it gets an R1 response or a timeout. The R1 byte goes back upstream with a single-cycle valid pulse.

---
 rtl/sd_cmd_framer_if.sv | 32 +++
 rtl/sd_cmd_framer.sv | 154 +++++++++++++++
 tb/tb_sd_cmd_framer.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/sd_cmd_framer_if.sv
// Signal bundle between the SD read controller, the command framer and the
// byte-wide SPI engine. The framer sits on the slave modport; whatever drives
// commands and services byte transfers uses the master modport.
interface sd_cmd_framer_if;
  // command request from the sector-read controller
  logic [5:0]  cmd_index;
  logic [31:0] cmd_arg;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        busy;
  // R1 result back upstream
  logic [7:0]  resp_r1;
  logic        resp_valid;
  logic        resp_timeout;
  // byte transfer handshake with the SPI engine
  logic [7:0]  byte_tx;
  logic        byte_trigger;
  logic [7:0]  byte_rx;
  logic        byte_done;

  modport slave (
    input  cmd_index, cmd_arg, cmd_valid, byte_rx, byte_done,
    output cmd_ready, busy, resp_r1, resp_valid, resp_timeout,
           byte_tx, byte_trigger
  );

  modport master (
    output cmd_index, cmd_arg, cmd_valid, byte_rx, byte_done,
    input  cmd_ready, busy, resp_r1, resp_valid, resp_timeout,
           byte_tx, byte_trigger
  );
endinterface

// File: rtl/sd_cmd_framer.sv
// SD SPI-mode command framer: builds {01, index, arg, crc7, 1}, ships it as
// six byte transfers, then polls with 0xFF until an R1 byte (bit7 = 0) shows
// up or the poll budget runs out. Result leaves as a one-cycle resp_valid.
module sd_cmd_framer #(
  parameter int RESP_POLL_MAX = 8
) (
  input  logic           clk,
  input  logic           rst,
  sd_cmd_framer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SEND, POLL, DONE} state_t;

  localparam logic [7:0] POLL_LIMIT = 8'(RESP_POLL_MAX);
  localparam logic [2:0] LAST_BYTE  = 3'd5;

  // CRC7 (x^7 + x^3 + 1) advanced over one byte, MSB first.
  function automatic logic [6:0] crc7_byte(input logic [6:0] crc_in,
                                           input logic [7:0] data);
    logic [6:0] c;
    logic       fb;
    c = crc_in;
    for (int i = 7; i >= 0; i--) begin
      fb = c[6] ^ data[i];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  state_t      state;
  logic [39:0] frame;      // {2'b01, index, arg} latched at accept
  logic [2:0]  byte_idx;   // frame byte currently in flight
  logic [7:0]  poll_cnt;   // poll bytes already answered with bit7=1
  logic [6:0]  crc;

  logic        cmd_ready_r;
  logic        busy_r;
  logic [7:0]  resp_r1_r;
  logic        resp_valid_r;
  logic        resp_timeout_r;
  logic [7:0]  byte_tx_r;
  logic        byte_trigger_r;

  logic [2:0]  next_idx;
  logic [7:0]  next_byte;
  logic [7:0]  poll_nxt;
  logic [7:0]  first_byte;

  assign next_idx   = byte_idx + 3'd1;
  assign poll_nxt   = poll_cnt + 8'd1;
  assign first_byte = {2'b01, bus.cmd_index};

  // Pick the frame byte that follows the one in flight. Byte 5 carries the
  // CRC, which is already final because byte 4 updated it when triggered.
  always_comb begin
    next_byte = 8'hFF;
    case (next_idx)
      3'd1:    next_byte = frame[31:24];
      3'd2:    next_byte = frame[23:16];
      3'd3:    next_byte = frame[15:8];
      3'd4:    next_byte = frame[7:0];
      default: next_byte = {crc, 1'b1};
    endcase
  end

  // Main control FSM; every output is a register so the SPI side sees clean
  // single-cycle trigger pulses and stable byte_tx.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      frame          <= '0;
      byte_idx       <= '0;
      poll_cnt       <= '0;
      crc            <= '0;
      cmd_ready_r    <= 1'b1;
      busy_r         <= 1'b0;
      resp_r1_r      <= 8'hFF;
      resp_valid_r   <= 1'b0;
      resp_timeout_r <= 1'b0;
      byte_tx_r      <= 8'hFF;
      byte_trigger_r <= 1'b0;
    end else begin
      byte_trigger_r <= 1'b0;
      resp_valid_r   <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            // byte 0 goes out right away, so CRC starts from 0 and absorbs it now
            frame          <= {first_byte, bus.cmd_arg};
            byte_idx       <= '0;
            poll_cnt       <= '0;
            resp_timeout_r <= 1'b0;
            crc            <= crc7_byte(7'h00, first_byte);
            byte_tx_r      <= first_byte;
            byte_trigger_r <= 1'b1;
            cmd_ready_r    <= 1'b0;
            busy_r         <= 1'b1;
            state          <= SEND;
          end
        end
        SEND: begin
          if (bus.byte_done) begin
            if (byte_idx == LAST_BYTE) begin
              byte_tx_r      <= 8'hFF;
              byte_trigger_r <= 1'b1;
              state          <= POLL;
            end else begin
              byte_idx       <= next_idx;
              byte_tx_r      <= next_byte;
              byte_trigger_r <= 1'b1;
              if (next_idx != LAST_BYTE)
                crc <= crc7_byte(crc, next_byte);
            end
          end
        end
        POLL: begin
          if (bus.byte_done) begin
            if (!bus.byte_rx[7]) begin
              resp_r1_r    <= bus.byte_rx;
              resp_valid_r <= 1'b1;
              state        <= DONE;
            end else if (poll_nxt == POLL_LIMIT) begin
              resp_r1_r      <= 8'hFF;
              resp_timeout_r <= 1'b1;
              resp_valid_r   <= 1'b1;
              poll_cnt       <= poll_nxt;
              state          <= DONE;
            end else begin
              poll_cnt       <= poll_nxt;
              byte_tx_r      <= 8'hFF;
              byte_trigger_r <= 1'b1;
            end
          end
        end
        DONE: begin
          cmd_ready_r <= 1'b1;
          busy_r      <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.cmd_ready    = cmd_ready_r;
  assign bus.busy         = busy_r;
  assign bus.resp_r1      = resp_r1_r;
  assign bus.resp_valid   = resp_valid_r;
  assign bus.resp_timeout = resp_timeout_r;
  assign bus.byte_tx      = byte_tx_r;
  assign bus.byte_trigger = byte_trigger_r;

endmodule

// File: tb/tb_sd_cmd_framer.sv
// Directed bench for sd_cmd_framer: a small SPI responder acks every byte
// one cycle after its trigger and feeds poll answers from a queue.
module tb_sd_cmd_framer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sd_cmd_framer_if ifc();

  sd_cmd_framer #(.RESP_POLL_MAX(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  int         n_tests = 0;
  int         n_fail  = 0;
  string      tname   = "reset";
  logic [7:0] cap_q[$];
  logic [7:0] rx_q[$];
  int         trig_cnt = 0;
  int         rv_cnt   = 0;
  int         hold_at  = 1000;
  logic [7:0] rv_r1    = 8'h00;
  logic       rv_to    = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s/%s: got %0h expected %0h", tname, tag, got, exp);
    end
  endtask

  // SPI responder: records each triggered byte, acks it the next cycle.
  initial begin : responder
    logic [7:0] cur_tx;
    ifc.byte_done = 1'b0;
    ifc.byte_rx   = 8'hFF;
    forever begin
      @(posedge clk); #1;
      while (ifc.byte_trigger === 1'b1) begin
        cur_tx = ifc.byte_tx;
        cap_q.push_back(cur_tx);
        trig_cnt++;
        if (trig_cnt == hold_at) break;
        @(posedge clk); #1;
        chk("tx_stable", ifc.byte_tx, cur_tx);
        if (trig_cnt > 6 && rx_q.size() > 0) ifc.byte_rx = rx_q.pop_front();
        else ifc.byte_rx = 8'hFF;
        ifc.byte_done = 1'b1;
        @(posedge clk); #1;
        ifc.byte_done = 1'b0;
        ifc.byte_rx   = 8'hFF;
      end
    end
  end

  // Response monitor.
  initial begin : monitor
    forever begin
      @(posedge clk); #1;
      if (ifc.resp_valid === 1'b1) begin
        rv_cnt++;
        rv_r1 = ifc.resp_r1;
        rv_to = ifc.resp_timeout;
      end
    end
  end

  task automatic run_cmd(input logic [5:0] idx, input logic [31:0] arg, input bit dbl);
    int n;
    cap_q.delete();
    trig_cnt = 0;
    rv_cnt   = 0;
    chk("ready_before", ifc.cmd_ready, 1'b1);
    ifc.cmd_index = idx;
    ifc.cmd_arg   = arg;
    ifc.cmd_valid = 1'b1;
    @(posedge clk); #2;
    ifc.cmd_valid = 1'b0;
    if (dbl) begin
      @(posedge clk); #2;
      ifc.cmd_index = 6'd17;
      ifc.cmd_arg   = 32'hDEAD_BEEF;
      ifc.cmd_valid = 1'b1;
      @(posedge clk); #2;
      ifc.cmd_valid = 1'b0;
    end
    n = 0;
    while (rv_cnt == 0 && n < 400) begin
      @(posedge clk); #2;
      n++;
    end
    chk("resp_seen", rv_cnt > 0, 1'b1);
    chk("busy_in_done", ifc.busy, 1'b1);
    chk("ready_in_done", ifc.cmd_ready, 1'b0);
    @(posedge clk); #2;
    chk("ready_after", ifc.cmd_ready, 1'b1);
    chk("valid_pulse", ifc.resp_valid, 1'b0);
    repeat (5) @(posedge clk);
    #2;
  endtask

  task automatic check_result(input logic [47:0] exp_frame, input int exp_trig,
                              input logic [7:0] exp_r1, input logic exp_to);
    logic [47:0] frm;
    frm = '0;
    chk("trig_count", trig_cnt, exp_trig);
    if (cap_q.size() >= 6)
      frm = {cap_q[0], cap_q[1], cap_q[2], cap_q[3], cap_q[4], cap_q[5]};
    chk("frame", frm, exp_frame);
    for (int i = 6; i < cap_q.size(); i++) chk("poll_byte", cap_q[i], 8'hFF);
    chk("resp_count", rv_cnt, 1);
    chk("resp_r1", rv_r1, exp_r1);
    chk("resp_timeout", rv_to, exp_to);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_ready", ifc.cmd_ready, 1'b1);
    chk("rst_busy", ifc.busy, 1'b0);
    chk("rst_r1", ifc.resp_r1, 8'hFF);
    chk("rst_valid", ifc.resp_valid, 1'b0);
    chk("rst_timeout", ifc.resp_timeout, 1'b0);
    chk("rst_tx", ifc.byte_tx, 8'hFF);
    chk("rst_trigger", ifc.byte_trigger, 1'b0);
  endtask

  initial begin : stim
    int n;
    ifc.cmd_valid = 1'b0;
    ifc.cmd_index = '0;
    ifc.cmd_arg   = '0;
    repeat (3) @(posedge clk);
    #2;
    chk_reset_outputs();
    rst = 1'b0;
    @(posedge clk); #2;

    tname = "cmd0";
    rx_q = '{8'hFF, 8'hFF, 8'h01};
    run_cmd(6'd0, 32'h0, 1'b0);
    check_result(48'h40_00_00_00_00_95, 9, 8'h01, 1'b0);

    tname = "cmd8";
    rx_q = '{8'h01};
    run_cmd(6'd8, 32'h0000_01AA, 1'b0);
    check_result(48'h48_00_00_01_AA_87, 7, 8'h01, 1'b0);

    tname = "cmd17";
    rx_q = '{8'h00};
    run_cmd(6'd17, 32'h0, 1'b0);
    check_result(48'h51_00_00_00_00_55, 7, 8'h00, 1'b0);

    tname = "timeout";
    rx_q.delete();
    run_cmd(6'd55, 32'h0, 1'b0);
    check_result(48'h77_00_00_00_00_65, 14, 8'hFF, 1'b1);

    tname = "busy_ignore";
    rx_q = '{8'h01};
    run_cmd(6'd8, 32'h0000_01AA, 1'b1);
    check_result(48'h48_00_00_01_AA_87, 7, 8'h01, 1'b0);
    repeat (20) @(posedge clk);
    #2;
    chk("no_extra_trig", trig_cnt, 7);
    chk("no_extra_resp", rv_cnt, 1);

    // abort mid-frame: responder stops acking at byte 3
    tname = "mid_reset";
    cap_q.delete();
    trig_cnt = 0;
    rv_cnt   = 0;
    hold_at  = 4;
    ifc.cmd_index = 6'd17;
    ifc.cmd_arg   = 32'h0;
    ifc.cmd_valid = 1'b1;
    @(posedge clk); #2;
    ifc.cmd_valid = 1'b0;
    n = 0;
    while (trig_cnt < 4 && n < 200) begin
      @(posedge clk); #2;
      n++;
    end
    chk("reached_byte3", trig_cnt, 4);
    rst = 1'b1;
    @(posedge clk); #2;
    chk_reset_outputs();
    rst = 1'b0;
    hold_at = 1000;
    ifc.byte_rx   = 8'h00;
    ifc.byte_done = 1'b1;
    @(posedge clk); #2;
    ifc.byte_done = 1'b0;
    ifc.byte_rx   = 8'hFF;
    repeat (20) @(posedge clk);
    #2;
    chk("no_trig_after", trig_cnt, 4);
    chk("no_resp_after", rv_cnt, 0);
    chk("idle_ready", ifc.cmd_ready, 1'b1);
    chk("idle_busy", ifc.busy, 1'b0);

    tname = "cmd0_again";
    rx_q = '{8'hFF, 8'hFF, 8'h01};
    run_cmd(6'd0, 32'h0, 1'b0);
    check_result(48'h40_00_00_00_00_95, 9, 8'h01, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
